control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL expose exactly these ports:
- CLK  in  1  system clock, rising-edge active.
- RST  in  1  asynchronous, active-low reset.
- OP_CODE  in  7  instruction[6:0].
- FUNCT_3  in  3  instruction[14:12].
- FUNCT_7  in  7  instruction[31:25].
- CRF  out  1  register-file write enable.
- CEU  out  3  immediate-extension format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 I-shamt (zero-extended imm[4:0]).
- CALU  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRA, 111 SRL.
- CDM  out  1  data-memory write enable.
- PCS  out  2  next-PC source: 00 PC+4, 01 conditional branch PC+imm, 10 JAL PC+imm, 11 JALR rs1+imm.
- DWS  out  2  write-back source: 00 ALU result, 01 data-memory read, 10 PC+4; 11 reserved, never driven.
- ALUS1  out  1  ALU operand A: 0 rs1, 1 constant zero.
- ALUS2  out  1  ALU operand B: 0 rs2, 1 extended immediate.
- OS  out  1  branch condition: 0 taken when rs1!=rs2 (BNE), 1 taken when rs1>=rs2 signed (BGE).
- BS  out  1  1 = current instruction is a conditional branch.
REQ-002 Clocking is fixed: one clock, CLK; reset RST is asynchronous and active-low.

Function
REQ-003 Outputs SHALL be registered: inputs sampled on each CLK rising edge and the decoded control word presented on that edge (1-cycle latency). No combinational input-to-output path.
REQ-004 Don't-care outputs in the table below SHALL be 0. Unlisted fields SHALL be 0.
REQ-005 OP 0010011, I-type ALU: CRF=1, ALUS2=1, DWS=00, PCS=00, CEU=000.
- F3 000 ADD.
- F3 100 XOR.
- F3 110 OR.
- F3 111 AND.
- F3 001 SLL with CEU=101.
- F3 101: SRA if F7=0100000, else SRL; CEU=101.
- F3 010/011 unsupported.
REQ-006 OP 0000011 with F3 010 (LW): CRF=1, CEU=000, CALU=ADD, ALUS2=1, DWS=01.
REQ-007 OP 0100011 with F3 010 (SW): CDM=1, CRF=0, CEU=001, CALU=ADD, ALUS2=1.
REQ-008 OP 0110011, R-type: CRF=1, ALUS2=0, DWS=00.
- F7 0000000: F3 000 ADD, 001 SLL, 100 XOR, 101 SRL, 110 OR, 111 AND.
- F7 0100000: F3 000 SUB, 101 SRA.
- All other F3/F7 combinations unsupported.
REQ-009 OP 0110111 (LUI): CRF=1, CEU=011, ALUS1=1, ALUS2=1, CALU=ADD, DWS=00.
REQ-010 OP 1100011, branch: BS=1, PCS=01, CEU=010, CALU=SUB, ALUS2=0, CRF=0.
- F3 001 BNE: OS=0.
- F3 101 BGE: OS=1.
- Other F3 values unsupported.
REQ-011 OP 1101111 (JAL): CRF=1, CEU=100, PCS=10, DWS=10.
REQ-012 OP 1100111 with F3 000 (JALR): CRF=1, CEU=000, PCS=11, DWS=10, CALU=ADD, ALUS2=1.
REQ-013 Any unsupported opcode or funct combination SHALL register the NOP word: all outputs 0. This gives PC+4 with no register or memory write.
REQ-014 FUNCT_7 SHALL be ignored except for OP 0110011 and for OP 0010011 with F3 101.

Reset
REQ-015 While RST=0, all outputs SHALL be 0 (the NOP word), asynchronously, independent of CLK.
REQ-016 On RST rising, the first decoded word SHALL appear at the first CLK rising edge after RST=1. Reset asserted mid-stream SHALL immediately force NOP, discarding the registered word.

Verification
REQ-017 Reset: RST=0 with OP 0110011 applied -> all outputs 0 with no clock edge; release RST, then one edge -> CRF=1, CALU=000.
REQ-018 ADDI (OP 0010011, F3 000) -> after one edge: CRF=1, CEU=000, CALU=000, ALUS2=1, PCS=00, DWS=00. SRAI (F3 101, F7 0100000) -> CALU=110, CEU=101.
REQ-019 SUB (OP 0110011, F3 000, F7 0100000) -> CALU=001, CRF=1, ALUS2=0. SLL (F3 001, F7 0) -> CALU=101.
REQ-020 SW (OP 0100011, F3 010) -> CDM=1, CRF=0, CEU=001, ALUS2=1. LUI (OP 0110111) -> CEU=011, ALUS1=1, CRF=1.
REQ-021 BGE (OP 1100011, F3 101) -> BS=1, OS=1, PCS=01, CEU=010, CALU=001. BNE -> OS=0. JAL -> PCS=10, DWS=10, CEU=100. JALR -> PCS=11, DWS=10.
REQ-022 Illegal: OP 0000000, or OP 0110011 with F7 0000001 -> all outputs 0.

Source files
------------

// File: rtl/control_unit.sv
// RV32 subset main decoder: opcode/funct fields to a registered control word.
// Unsupported encodings decode to the all-zero NOP word (PC+4, no writes).
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] OP_CODE,
  input  logic [2:0] FUNCT_3,
  input  logic [6:0] FUNCT_7,
  output logic       CRF,
  output logic [2:0] CEU,
  output logic [2:0] CALU,
  output logic       CDM,
  output logic [1:0] PCS,
  output logic [1:0] DWS,
  output logic       ALUS1,
  output logic       ALUS2,
  output logic       OS,
  output logic       BS
);

  typedef struct packed {
    logic       crf;
    logic [2:0] ceu;
    logic [2:0] calu;
    logic       cdm;
    logic [1:0] pcs;
    logic [1:0] dws;
    logic       alus1;
    logic       alus2;
    logic       os;
    logic       bs;
  } ctrl_t;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_REG  = 7'b0110011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [2:0] A_ADD = 3'b000;
  localparam logic [2:0] A_SUB = 3'b001;
  localparam logic [2:0] A_AND = 3'b010;
  localparam logic [2:0] A_OR  = 3'b011;
  localparam logic [2:0] A_XOR = 3'b100;
  localparam logic [2:0] A_SLL = 3'b101;
  localparam logic [2:0] A_SRA = 3'b110;
  localparam logic [2:0] A_SRL = 3'b111;

  localparam logic [2:0] E_I  = 3'b000;
  localparam logic [2:0] E_S  = 3'b001;
  localparam logic [2:0] E_B  = 3'b010;
  localparam logic [2:0] E_U  = 3'b011;
  localparam logic [2:0] E_J  = 3'b100;
  localparam logic [2:0] E_SH = 3'b101;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  ctrl_t w_ctrl;
  ctrl_t r_ctrl;
  logic  w_ok;

  // Decode the current fields; any illegal leaf clears the whole word.
  always_comb begin
    w_ctrl = '0;
    w_ok   = 1'b1;
    case (OP_CODE)
      OP_IMM: begin
        w_ctrl.crf   = 1'b1;
        w_ctrl.alus2 = 1'b1;
        case (FUNCT_3)
          3'b000: w_ctrl.calu = A_ADD;
          3'b100: w_ctrl.calu = A_XOR;
          3'b110: w_ctrl.calu = A_OR;
          3'b111: w_ctrl.calu = A_AND;
          3'b001: begin
            w_ctrl.calu = A_SLL;
            w_ctrl.ceu  = E_SH;
          end
          3'b101: begin
            w_ctrl.calu = (FUNCT_7 == F7_ALT) ? A_SRA : A_SRL;
            w_ctrl.ceu  = E_SH;
          end
          default: w_ok = 1'b0;
        endcase
      end
      OP_LD: begin
        w_ok         = (FUNCT_3 == 3'b010);
        w_ctrl.crf   = 1'b1;
        w_ctrl.alus2 = 1'b1;
        w_ctrl.dws   = 2'b01;
      end
      OP_ST: begin
        w_ok         = (FUNCT_3 == 3'b010);
        w_ctrl.cdm   = 1'b1;
        w_ctrl.ceu   = E_S;
        w_ctrl.alus2 = 1'b1;
      end
      OP_REG: begin
        w_ctrl.crf = 1'b1;
        unique case (1'b1)
          (FUNCT_7 == 7'd0): begin
            case (FUNCT_3)
              3'b000: w_ctrl.calu = A_ADD;
              3'b001: w_ctrl.calu = A_SLL;
              3'b100: w_ctrl.calu = A_XOR;
              3'b101: w_ctrl.calu = A_SRL;
              3'b110: w_ctrl.calu = A_OR;
              3'b111: w_ctrl.calu = A_AND;
              default: w_ok = 1'b0;
            endcase
          end
          (FUNCT_7 == F7_ALT): begin
            case (FUNCT_3)
              3'b000: w_ctrl.calu = A_SUB;
              3'b101: w_ctrl.calu = A_SRA;
              default: w_ok = 1'b0;
            endcase
          end
          default: w_ok = 1'b0;
        endcase
      end
      OP_LUI: begin
        w_ctrl.crf   = 1'b1;
        w_ctrl.ceu   = E_U;
        w_ctrl.alus1 = 1'b1;
        w_ctrl.alus2 = 1'b1;
      end
      OP_BR: begin
        w_ctrl.bs   = 1'b1;
        w_ctrl.pcs  = 2'b01;
        w_ctrl.ceu  = E_B;
        w_ctrl.calu = A_SUB;
        case (FUNCT_3)
          3'b001: w_ctrl.os = 1'b0;
          3'b101: w_ctrl.os = 1'b1;
          default: w_ok = 1'b0;
        endcase
      end
      OP_JAL: begin
        w_ctrl.crf = 1'b1;
        w_ctrl.ceu = E_J;
        w_ctrl.pcs = 2'b10;
        w_ctrl.dws = 2'b10;
      end
      OP_JALR: begin
        w_ok         = (FUNCT_3 == 3'b000);
        w_ctrl.crf   = 1'b1;
        w_ctrl.ceu   = E_I;
        w_ctrl.pcs   = 2'b11;
        w_ctrl.dws   = 2'b10;
        w_ctrl.alus2 = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
    if (!w_ok) w_ctrl = '0;
  end

  // Register the decoded word; reset forces NOP immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_ctrl <= '0;
    else      r_ctrl <= w_ctrl;
  end

  assign CRF   = r_ctrl.crf;
  assign CEU   = r_ctrl.ceu;
  assign CALU  = r_ctrl.calu;
  assign CDM   = r_ctrl.cdm;
  assign PCS   = r_ctrl.pcs;
  assign DWS   = r_ctrl.dws;
  assign ALUS1 = r_ctrl.alus1;
  assign ALUS2 = r_ctrl.alus2;
  assign OS    = r_ctrl.os;
  assign BS    = r_ctrl.bs;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: mnemonic-level reference model,
// directed and random instructions, async reset checks.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] OP_CODE = '0;
  logic [2:0] FUNCT_3 = '0;
  logic [6:0] FUNCT_7 = '0;
  logic       CRF, CDM, ALUS1, ALUS2, OS, BS;
  logic [2:0] CEU, CALU;
  logic [1:0] PCS, DWS;

  int nrun = 0;
  int nfail = 0;

  typedef enum {
    M_NOP, M_ADDI, M_XORI, M_ORI, M_ANDI, M_SLLI, M_SRLI, M_SRAI,
    M_LW, M_SW, M_ADD, M_SUB, M_SLL, M_XOR, M_SRL, M_SRA, M_OR,
    M_AND, M_LUI, M_BNE, M_BGE, M_JAL, M_JALR
  } mn_t;

  typedef struct {
    logic [15:0] w;
    mn_t         m;
  } exp_t;

  exp_t q[$];

  control_unit dut (
    .CLK(CLK), .RST(RST), .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3),
    .FUNCT_7(FUNCT_7), .CRF(CRF), .CEU(CEU), .CALU(CALU), .CDM(CDM),
    .PCS(PCS), .DWS(DWS), .ALUS1(ALUS1), .ALUS2(ALUS2), .OS(OS), .BS(BS)
  );

  always #5 CLK = ~CLK;

  wire [15:0] act = {CRF, CEU, CALU, CDM, PCS, DWS, ALUS1, ALUS2, OS, BS};

  // Identify the instruction from its encoding.
  function automatic mn_t classify(logic [6:0] op, logic [2:0] f3,
                                   logic [6:0] f7);
    if (op == 7'b0010011) begin
      if (f3 == 0) return M_ADDI;
      if (f3 == 4) return M_XORI;
      if (f3 == 6) return M_ORI;
      if (f3 == 7) return M_ANDI;
      if (f3 == 1) return M_SLLI;
      if (f3 == 5) return (f7 == 7'h20) ? M_SRAI : M_SRLI;
      return M_NOP;
    end
    if (op == 7'b0000011) return (f3 == 2) ? M_LW : M_NOP;
    if (op == 7'b0100011) return (f3 == 2) ? M_SW : M_NOP;
    if (op == 7'b0110011) begin
      if (f7 == 0) begin
        if (f3 == 0) return M_ADD;
        if (f3 == 1) return M_SLL;
        if (f3 == 4) return M_XOR;
        if (f3 == 5) return M_SRL;
        if (f3 == 6) return M_OR;
        if (f3 == 7) return M_AND;
      end
      if (f7 == 7'h20 && f3 == 0) return M_SUB;
      if (f7 == 7'h20 && f3 == 5) return M_SRA;
      return M_NOP;
    end
    if (op == 7'b0110111) return M_LUI;
    if (op == 7'b1100011) begin
      if (f3 == 1) return M_BNE;
      if (f3 == 5) return M_BGE;
      return M_NOP;
    end
    if (op == 7'b1101111) return M_JAL;
    if (op == 7'b1100111) return (f3 == 0) ? M_JALR : M_NOP;
    return M_NOP;
  endfunction

  // {CRF,CEU,CALU,CDM,PCS,DWS,ALUS1,ALUS2,OS,BS}
  function automatic logic [15:0] cw(bit crf, bit [2:0] ceu, bit [2:0] alu,
      bit cdm, bit [1:0] pcs, bit [1:0] dws, bit a1, bit a2, bit os, bit bs);
    return {crf, ceu, alu, cdm, pcs, dws, a1, a2, os, bs};
  endfunction

  // Control word each instruction requires.
  function automatic logic [15:0] word_of(mn_t m);
    case (m)
      M_ADDI: return cw(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      M_XORI: return cw(1, 0, 4, 0, 0, 0, 0, 1, 0, 0);
      M_ORI:  return cw(1, 0, 3, 0, 0, 0, 0, 1, 0, 0);
      M_ANDI: return cw(1, 0, 2, 0, 0, 0, 0, 1, 0, 0);
      M_SLLI: return cw(1, 5, 5, 0, 0, 0, 0, 1, 0, 0);
      M_SRLI: return cw(1, 5, 7, 0, 0, 0, 0, 1, 0, 0);
      M_SRAI: return cw(1, 5, 6, 0, 0, 0, 0, 1, 0, 0);
      M_LW:   return cw(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      M_SW:   return cw(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
      M_ADD:  return cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      M_SUB:  return cw(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      M_SLL:  return cw(1, 0, 5, 0, 0, 0, 0, 0, 0, 0);
      M_XOR:  return cw(1, 0, 4, 0, 0, 0, 0, 0, 0, 0);
      M_SRL:  return cw(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
      M_SRA:  return cw(1, 0, 6, 0, 0, 0, 0, 0, 0, 0);
      M_OR:   return cw(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
      M_AND:  return cw(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
      M_LUI:  return cw(1, 3, 0, 0, 0, 0, 1, 1, 0, 0);
      M_BNE:  return cw(0, 2, 1, 0, 1, 0, 0, 0, 0, 1);
      M_BGE:  return cw(0, 2, 1, 0, 1, 0, 0, 0, 1, 1);
      M_JAL:  return cw(1, 4, 0, 0, 2, 2, 0, 0, 0, 0);
      M_JALR: return cw(1, 0, 0, 0, 3, 2, 0, 1, 0, 0);
      default: return 16'h0;
    endcase
  endfunction

  task automatic check_now(string name, logic [15:0] want);
    nrun++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic issue(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
    exp_t e;
    @(negedge CLK);
    OP_CODE = op;
    FUNCT_3 = f3;
    FUNCT_7 = f7;
    e.m = classify(op, f3, f7);
    e.w = word_of(e.m);
    q.push_back(e);
  endtask

  // Monitor: compare the registered word after each edge.
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      nrun++;
      if (act !== e.w) begin
        nfail++;
        $display("FAIL %s: got %h want %h", e.m.name(), act, e.w);
      end
    end
  end

  logic [6:0] ops [10];

  initial begin
    ops = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b0110011, 7'b0110111,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0000000, 7'b1111111};

    OP_CODE = 7'b0110011;
    #2;
    check_now("reset_async", 16'h0);
    repeat (2) @(posedge CLK);
    #1;
    check_now("reset_held", 16'h0);
    @(negedge CLK);
    RST = 1'b1;
    issue(7'b0110011, 3'd0, 7'h00);

    issue(7'b0010011, 3'd0, 7'h00);
    issue(7'b0010011, 3'd5, 7'h20);
    issue(7'b0110011, 3'd0, 7'h20);
    issue(7'b0110011, 3'd1, 7'h00);
    issue(7'b0100011, 3'd2, 7'h00);
    issue(7'b0110111, 3'd3, 7'h55);
    issue(7'b1100011, 3'd5, 7'h00);
    issue(7'b1100011, 3'd1, 7'h7f);
    issue(7'b1101111, 3'd6, 7'h11);
    issue(7'b1100111, 3'd0, 7'h00);
    issue(7'b0000000, 3'd0, 7'h00);
    issue(7'b0110011, 3'd0, 7'h01);
    issue(7'b0010011, 3'd5, 7'h01);
    issue(7'b0010011, 3'd2, 7'h00);
    issue(7'b0000011, 3'd2, 7'h33);
    issue(7'b1100111, 3'd1, 7'h00);

    // Mid-stream reset discards the registered word.
    issue(7'b1101111, 3'd0, 7'h00);
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_now("reset_mid", 16'h0);
    @(posedge CLK);
    #1;
    check_now("reset_mid_edge", 16'h0);
    #2;
    RST = 1'b1;
    issue(7'b0000011, 3'd2, 7'h00);

    for (int i = 0; i < 400; i++) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      issue(ops[$urandom_range(0, 9)], 3'($urandom), f7);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    #2;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
